// File: rtl/reg_wr_arbiter.sv
// Round-robin write arbiter in front of a single enabled data register.
// A grant captures the winner's data and drives the register for exactly one cycle.
module reg_wr_arbiter #(
  parameter int NREQ = 4,
  parameter int SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*SIZE-1:0] wdat,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic                 reg_ena,
  output logic [SIZE-1:0]      reg_idat
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            busy_q, busy_d;
  logic            reg_ena_q, reg_ena_d;
  logic [SIZE-1:0] reg_idat_q, reg_idat_d;

  logic [SIZE-1:0] wdat_a [NREQ];
  logic            found;
  logic [PW-1:0]   win;
  logic [PW:0]     cand;

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign wdat_a[i] = wdat[i*SIZE +: SIZE];
  end

  // First set request at or after ptr, wrapping modulo NREQ (NREQ need not be a power of two).
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = {1'b0, ptr_q} + (PW+1)'(off);
      if (cand >= (PW+1)'(NREQ)) cand = cand - (PW+1)'(NREQ);
      if (!found && req[cand[PW-1:0]]) begin
        found = 1'b1;
        win   = cand[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
    gnt_d      = '0;
    busy_d     = 1'b0;
    reg_ena_d  = 1'b0;
    reg_idat_d = reg_idat_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d    = WRITE;
          win_d      = win;
          gnt_d      = {{(NREQ-1){1'b0}}, 1'b1} << win;
          busy_d     = 1'b1;
          reg_ena_d  = 1'b1;
          reg_idat_d = wdat_a[win];
        end
      end
      WRITE: begin
        // req is ignored here: a granted write always completes.
        state_d = IDLE;
        ptr_d   = (win_q == PW'(NREQ-1)) ? '0 : win_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      win_q      <= '0;
      gnt_q      <= '0;
      busy_q     <= 1'b0;
      reg_ena_q  <= 1'b0;
      reg_idat_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
      gnt_q      <= gnt_d;
      busy_q     <= busy_d;
      reg_ena_q  <= reg_ena_d;
      reg_idat_q <= reg_idat_d;
    end
  end

  assign gnt      = gnt_q;
  assign busy     = busy_q;
  assign reg_ena  = reg_ena_q;
  assign reg_idat = reg_idat_q;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Bench for reg_wr_arbiter: directed scenarios, then randomized requesters
// checked every cycle against a round-robin reference model.
module tb_reg_wr_arbiter;
  localparam int NREQ = 4;
  localparam int SIZE = 8;

  logic                 clk = 1'b0;
  logic                 rst = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*SIZE-1:0] wdat = '0;
  logic [NREQ-1:0]      gnt;
  logic                 busy;
  logic                 reg_ena;
  logic [SIZE-1:0]      reg_idat;

  reg_wr_arbiter #(.NREQ(NREQ), .SIZE(SIZE)) dut (
    .clk(clk), .rst(rst), .req(req), .wdat(wdat),
    .gnt(gnt), .busy(busy), .reg_ena(reg_ena), .reg_idat(reg_idat)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Reference model: spec rules in plain integer arithmetic.
  int              m_ptr = 0;
  int              m_k = 0;
  bit              m_wr = 1'b0;
  logic [NREQ-1:0] m_gnt = '0;
  logic [SIZE-1:0] m_idat = '0;
  int              m_wait [NREQ];
  bit              m_found;
  int              m_i;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr = 0; m_wr = 1'b0; m_gnt = '0; m_idat = '0;
      for (int j = 0; j < NREQ; j++) m_wait[j] = 0;
    end else if (m_wr) begin
      m_ptr = (m_k + 1) % NREQ;
      m_wr  = 1'b0;
      m_gnt = '0;
    end else if (req != '0) begin
      m_found = 1'b0;
      for (int off = 0; off < NREQ; off++) begin
        m_i = (m_ptr + off) % NREQ;
        if (!m_found && req[m_i]) begin
          m_found = 1'b1;
          m_k = m_i;
        end
      end
      m_wr   = 1'b1;
      m_gnt  = '0;
      m_gnt[m_k] = 1'b1;
      m_idat = wdat[m_k*SIZE +: SIZE];
      chk("fairness", 32'(m_wait[m_k] <= NREQ - 1), 32'd1);
      for (int j = 0; j < NREQ; j++) begin
        if (j == m_k || !req[j]) m_wait[j] = 0;
        else m_wait[j] = m_wait[j] + 1;
      end
    end
  end

  logic [NREQ-1:0] gnt_prev = '0;

  always @(negedge clk) begin
    gnt_prev = gnt;
    chk("mdl_gnt", 32'(gnt), 32'(m_gnt));
    chk("mdl_ena", 32'(reg_ena), 32'(m_wr));
    chk("mdl_busy", 32'(busy), 32'(m_wr));
    chk("mdl_idat", 32'(reg_idat), 32'(m_idat));
  end

  task automatic chk_out(input string tag, input logic [NREQ-1:0] eg, input logic [SIZE-1:0] ed);
    chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
    chk({tag, "_ena"}, 32'(reg_ena), 32'(eg != '0));
    chk({tag, "_busy"}, 32'(busy), 32'(eg != '0));
    chk({tag, "_idat"}, 32'(reg_idat), 32'(ed));
  endtask

  logic [SIZE-1:0] slices [NREQ];

  initial begin
    for (int j = 0; j < NREQ; j++) m_wait[j] = 0;
    slices[0] = 8'h11; slices[1] = 8'h22; slices[2] = 8'hA5; slices[3] = 8'h44;
    #1 rst = 1'b1;
    req = 4'b1111;
    wdat = {slices[3], slices[2], slices[1], slices[0]};
    repeat (3) begin
      @(negedge clk);
      chk_out("reset", 4'b0000, 8'h00);
    end
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk);

    // Full load from reset: 0,1,2,3,0 every two cycles.
    for (int g = 0; g < 5; g++) begin
      @(negedge clk);
      chk_out("rr_grant", 4'(1 << (g % 4)), slices[g % 4]);
      @(negedge clk);
      chk_out("rr_gap", 4'b0000, slices[g % 4]);
    end

    // ptr is now 1; lone request from 2.
    req = 4'b0100;
    @(negedge clk);
    chk_out("single", 4'b0100, 8'hA5);
    req = 4'b0011;
    wdat[7:0] = 8'h5A; wdat[15:8] = 8'hC3;
    @(negedge clk);
    chk_out("single_done", 4'b0000, 8'hA5);

    // ptr = 3, req 0011: wrap to 0, then 1.
    @(negedge clk);
    chk_out("wrap0", 4'b0001, 8'h5A);
    req = 4'b0010;
    @(negedge clk);
    chk_out("wrap_gap", 4'b0000, 8'h5A);
    @(posedge clk); #1 req = 4'b0000;
    @(negedge clk);
    chk_out("drop_mid", 4'b0010, 8'hC3);
    repeat (3) begin
      @(negedge clk);
      chk_out("no_retry", 4'b0000, 8'hC3);
    end

    // ptr = 2; requester 1 wins, then reset hits mid-write.
    req = 4'b0010;
    wdat[15:8] = 8'hB7;
    @(posedge clk); #2;
    chk_out("pre_rst", 4'b0010, 8'hB7);
    rst = 1'b1;
    #1;
    chk_out("rst_mid", 4'b0000, 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    req = 4'b1010;
    wdat[31:24] = 8'hE1;
    @(negedge clk);
    chk_out("post_rst1", 4'b0010, 8'hB7);
    req = 4'b1000;
    @(negedge clk);
    chk_out("post_rst_gap", 4'b0000, 8'hB7);
    @(negedge clk);
    chk_out("post_rst3", 4'b1000, 8'hE1);
    req = 4'b0000;

    // Randomized requesters obeying the handshake, with rare reset pulses.
    for (int c = 0; c < 800; c++) begin
      @(posedge clk); #1;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 63) == 0) rst = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (gnt_prev[i]) begin
          req[i] = ($urandom_range(0, 3) == 0);
          if (req[i]) wdat[i*SIZE +: SIZE] = 8'($urandom);
        end else if (!req[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            req[i] = 1'b1;
            wdat[i*SIZE +: SIZE] = 8'($urandom);
          end
        end else if (m_wr && m_gnt[i] && $urandom_range(0, 7) == 0) begin
          req[i] = 1'b0;
        end
      end
    end
    rst = 1'b0;
    req = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
